// File: rtl/bitonic_sort_sched.sv
// Round-robin scheduler time-sharing one pipelined bitonic sorter among NUM_REQ requesters.
// Define BITONIC_SCHED_PRIO0_EN to give requester 0 strict priority over the round-robin group.
module bitonic_sort_sched #(
  parameter int DATAWIDTH  = 8,
  parameter int DATALENGTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int SORT_LAT   = 15,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NUM_REQ-1:0]                        req_valid_i,
  output logic [NUM_REQ-1:0]                        req_ready_o,
  input  logic [NUM_REQ*DATALENGTH*DATAWIDTH-1:0]   req_data_i,
  output logic                                      sort_valid_o,
  output logic [DATALENGTH*DATAWIDTH-1:0]           sort_x_o,
  input  logic                                      sort_valid_i,
  input  logic [DATALENGTH*DATAWIDTH-1:0]           sort_y_i,
  output logic [NUM_REQ-1:0]                        rsp_valid_o,
  output logic [DATALENGTH*DATAWIDTH-1:0]           rsp_data_o,
  output logic [$clog2(NUM_REQ)-1:0]                rsp_id_o,
  input  logic [NUM_REQ-1:0]                        rsp_ready_i,
  output logic                                      busy_o
);

  localparam int          VW  = DATALENGTH * DATAWIDTH;
  localparam int          IDW = $clog2(NUM_REQ);
  localparam int          CW  = $clog2(RSP_DEPTH + 1);
  localparam int          PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned NR  = NUM_REQ;
`ifdef BITONIC_SCHED_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic [IDW-1:0] r_ptr;
  logic [CW-1:0]  r_credits;
  logic [CW-1:0]  w_credits_nxt;
  logic [VW-1:0]  r_sort_x;
  logic           r_tag_v  [0:SORT_LAT];
  logic [IDW-1:0] r_tag_id [0:SORT_LAT];
  logic           r_tag_err;
  logic [VW-1:0]  r_fifo_data [RSP_DEPTH];
  logic [IDW-1:0] r_fifo_id   [RSP_DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic           r_busy;

  logic                w_hs;
  logic [IDW-1:0]      w_gid;
  logic [IDW-1:0]      w_idx;
  logic [NUM_REQ-1:0]  w_grant;
  logic                w_push;
  logic                w_pop;
  logic                w_empty;
  logic [IDW-1:0]      w_head_id;

  // Grant is gated by rst_i so req_ready_o reads zero while reset is held.
  always_comb begin
    w_hs    = 1'b0;
    w_gid   = '0;
    w_idx   = '0;
    w_grant = '0;
    if (r_credits != '0 && !rst_i) begin
      if (PRIO0 && req_valid_i[0]) begin
        w_hs  = 1'b1;
        w_gid = '0;
      end else begin
        for (int unsigned i = 0; i < NR; i++) begin
          w_idx = IDW'((32'(r_ptr) + i) % NR);
          if (!w_hs && req_valid_i[w_idx] && (!PRIO0 || w_idx != '0)) begin
            w_hs  = 1'b1;
            w_gid = w_idx;
          end
        end
      end
    end
    if (w_hs) w_grant[w_gid] = 1'b1;
  end

  assign w_push    = r_tag_v[SORT_LAT];
  assign w_empty   = (r_count == '0);
  assign w_head_id = r_fifo_id[r_rptr];
  assign w_pop     = !w_empty && rsp_ready_i[w_head_id];

  always_comb begin
    w_credits_nxt = r_credits;
    if (w_hs && !w_pop)      w_credits_nxt = r_credits - CW'(1);
    else if (!w_hs && w_pop) w_credits_nxt = r_credits + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr     <= '0;
      r_credits <= CW'(RSP_DEPTH);
      r_sort_x  <= '0;
      r_tag_err <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      for (int unsigned i = 0; i <= SORT_LAT; i++) begin
        r_tag_v[i]  <= 1'b0;
        r_tag_id[i] <= '0;
      end
    end else begin
      r_credits <= w_credits_nxt;
      r_busy    <= (w_credits_nxt != CW'(RSP_DEPTH));
      if (w_hs && (!PRIO0 || w_gid != '0))
        r_ptr <= (w_gid == IDW'(NUM_REQ - 1)) ? '0 : w_gid + IDW'(1);
      if (w_hs) r_sort_x <= req_data_i[w_gid*VW +: VW];
      // Stage 0 doubles as the issue strobe; stage SORT_LAT lines up with sort_valid_i.
      r_tag_v[0]  <= w_hs;
      r_tag_id[0] <= w_gid;
      for (int unsigned i = 1; i <= SORT_LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
      if (w_push && !sort_valid_i) r_tag_err <= 1'b1;
      if (w_push) r_wptr <= (r_wptr == PW'(RSP_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PW'(RSP_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= sort_y_i;
      r_fifo_id[r_wptr]   <= r_tag_id[SORT_LAT];
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (!w_empty) rsp_valid_o[w_head_id] = 1'b1;
  end

  assign req_ready_o  = w_grant;
  assign sort_valid_o = r_tag_v[0];
  assign sort_x_o     = r_sort_x;
  assign rsp_data_o   = w_empty ? '0 : r_fifo_data[r_rptr];
  assign rsp_id_o     = w_empty ? '0 : w_head_id;
  assign busy_o       = r_busy;

  a_credit_range: assert property (@(posedge clk_i) disable iff (rst_i)
    r_credits <= CW'(RSP_DEPTH));
  a_credit_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_hs && r_credits == '0));
  a_credit_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_pop && !w_hs && r_credits == CW'(RSP_DEPTH)));
  a_fifo_full_push: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && !w_pop && r_count == CW'(RSP_DEPTH)));
  a_tag_match: assert property (@(posedge clk_i) disable iff (rst_i) !r_tag_err);

endmodule

// File: doc/bitonic_sort_sched.md
Name: bitonic_sort_sched

Overview:
- Time-shares one pipelined 32-input bitonic sorter among NUM_REQ requesters.
- Each requester submits a full 32-element vector on a valid/ready handshake. The scheduler arbitrates round-robin and issues at most one vector per cycle to the sorter.
- It tags each issued vector with its requester ID, captures the sorted result into a response FIFO, and returns it to the originating requester.
- The sorter cannot stall, so issue is credit-gated on free response-FIFO space.

Parameters:
- DATAWIDTH, 8, bits per element
- DATALENGTH, 32, elements per vector (sorter width)
- NUM_REQ, 4, number of requesters (2..8)
- SORT_LAT, 15, fixed sorter latency in cycles from issue to result
- RSP_DEPTH, 4, response FIFO entries; also the total credit count

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-requester vector valid
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero
- req_data_i  in  NUM_REQ*DATALENGTH*DATAWIDTH  requester vectors; requester r occupies slice r
- sort_valid_o  out  1  issue strobe to sorter
- sort_x_o  out  DATALENGTH*DATAWIDTH  vector to sorter
- sort_valid_i  in  1  sorter result strobe, asserted exactly SORT_LAT cycles after sort_valid_o
- sort_y_i  in  DATALENGTH*DATAWIDTH  sorted vector from sorter
- rsp_valid_o  out  NUM_REQ  one-hot: FIFO head is valid for requester r
- rsp_data_o  out  DATALENGTH*DATAWIDTH  FIFO head data
- rsp_id_o  out  $clog2(NUM_REQ)  FIFO head requester ID
- rsp_ready_i  in  NUM_REQ  per-requester response accept
- busy_o  out  1  high when any vector is in flight or the FIFO is non-empty

Behaviour:
- Reset (async, rst_i=1):
  - All outputs are 0.
  - Credits = RSP_DEPTH; RR pointer = 0.
  - FIFO is empty; tag pipe is cleared.
  - Any in-flight vectors are discarded. sort_valid_i pulses that arrive after reset deassertion but belong to pre-reset issues are ignored, because the tag-pipe valid bit is 0.
- Arbitration:
  - Combinational grant over req_valid_i whenever credits > 0.
  - Round-robin, starting at the RR pointer.
  - req_ready_o[g]=1 only for the granted requester g.
  - On handshake, the RR pointer becomes (g+1) mod NUM_REQ. The pointer is unchanged when there is no grant.
- Issue:
  - Registered, latency 1. The cycle after a handshake: sort_valid_o=1 and sort_x_o=requester g's data captured at handshake.
  - Credits decrement by 1 on handshake.
  - Back-to-back issue every cycle is permitted while credits remain.
- Tag pipe:
  - SORT_LAT+1-deep shift register of {valid, id}, entered at the issue cycle.
  - When the output entry is valid, sort_valid_i must also be 1. A mismatch sets the sticky internal flag tag_err, which is visible in simulation only.
- Capture:
  - On a valid tag-pipe output, push {sort_y_i, id} into the FIFO.
  - Credits guarantee the FIFO is never full on a push.
- Response:
  - When the FIFO is non-empty: rsp_valid_o = onehot(head id); rsp_data_o and rsp_id_o show the head.
  - Pop when rsp_ready_i[head id]=1. Ready from other requesters is ignored.
  - Strict in-order delivery: head-of-line blocking is intended.
- Credits:
  - +1 on pop, -1 on issue handshake. Simultaneous pop and handshake leave credits unchanged.
  - Range is 0..RSP_DEPTH. Overflow or underflow is impossible by construction and asserted.
- Boundaries:
  - credits=0: req_ready_o is all zero and req_valid_i is ignored.
  - Pop and push in the same cycle with the FIFO full or empty are both legal. Pointers wrap mod RSP_DEPTH.
- busy_o = (credits != RSP_DEPTH), registered view.

Optional Feature:
- BITONIC_SCHED_PRIO0_EN defined:
  - Requester 0 has strict priority; whenever req_valid_i[0]=1 and credits > 0, it is granted.
  - Remaining requesters share round-robin among themselves; the RR pointer does not advance on a requester-0 grant.
- Undefined: pure round-robin over all NUM_REQ requesters.

Test Plan:
- Reset/idle: after reset all outputs are 0, busy_o=0. Assert req_valid_i=4'b0001 with credits=4 -> req_ready_o=4'b0001; sort_valid_o=1 next cycle; rsp_valid_o=4'b0001 at cycle 1+SORT_LAT+1.
- Round-robin: hold req_valid_i=4'b1111 for 4 cycles, rsp_ready_i=4'b1111 -> grants 0,1,2,3 in order; responses return with rsp_id_o=0,1,2,3.
- Credit exhaustion: rsp_ready_i=0 and all requesters valid -> exactly 4 handshakes, then req_ready_o=0. Pop one -> exactly one more grant on the following cycle.
- Head-of-line blocking: FIFO head id=2 with rsp_ready_i=4'b1011 -> no pop. Raise bit 2 -> pop, and the next head is presented.
- Data integrity: the sorter model returns the reversed input vector 0..31 -> rsp_data_o matches the model output bit-exactly for the correct id.
- Mid-flight reset: pulse rst_i with 3 vectors in flight -> outputs 0 immediately; post-reset sort_valid_i pulses are ignored; credits=4; no rsp_valid_o.
